// File: rtl/jt5205_pkg.sv
//------------------------------------------------------------------------------
// Module      : jt5205_pkg
// Description : Shared constants and helpers for the jt5205 N-times interpolator
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package jt5205_pkg;

   localparam int c_def_dw    = 12;
   localparam int c_def_log2n = 2;

   // Phase counts 0..N, so it needs one more bit than log2(N)
   function automatic int phase_w(input int log2n);
      return $clog2(1 << log2n) + 1;
   endfunction

   // Saturated phase value that marks HOLD
   function automatic int hold_n(input int log2n);
      return 1 << log2n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/jt5205_interpol_ch.sv
//------------------------------------------------------------------------------
// Module      : jt5205_interpol_ch
// Description : One channel of the interpolator: cur, delta, acc and output reg.
//               JT5205_INTERPOL_ROUND_EN selects round-half-up output.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jt5205_interpol_ch
   import jt5205_pkg::*;
#(
   parameter int DW    = c_def_dw,
   parameter int LOG2N = c_def_log2n
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_load,
   input  logic          i_step,
   input  logic          i_hold,
   input  logic [DW-1:0] i_din,
   output logic [DW-1:0] o_dout
);

   localparam int c_aw = DW + LOG2N + 1;

   logic signed [DW-1:0]   r_cur;
   logic signed [DW:0]     r_delta;
   logic signed [c_aw-1:0] r_acc;
   logic signed [DW-1:0]   r_dout;

   logic signed [DW:0]     w_delta_new;
   logic signed [c_aw-1:0] w_cur_sc;
   logic signed [c_aw-1:0] w_delta_new_ext;
   logic signed [c_aw-1:0] w_delta_ext;
   logic signed [DW-1:0]   w_out;

   assign w_delta_new     = {i_din[DW-1], i_din} - {r_cur[DW-1], r_cur};
   assign w_cur_sc        = {r_cur[DW-1], r_cur, {LOG2N{1'b0}}};
   assign w_delta_new_ext = {{LOG2N{w_delta_new[DW]}}, w_delta_new};
   assign w_delta_ext     = {{LOG2N{r_delta[DW]}}, r_delta};

   // acc stays within [min*N, max*N], so the selected field never overflows
`ifdef JT5205_INTERPOL_ROUND_EN
   assign w_out = r_acc[LOG2N +: DW] + DW'(r_acc[LOG2N-1]);
`else
   assign w_out = r_acc[LOG2N +: DW];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur   <= '0;
         r_delta <= '0;
         r_acc   <= '0;
         r_dout  <= '0;
      end else if (i_load) begin
         r_cur   <= i_din;
         r_delta <= w_delta_new;
         if (i_step) begin
            // Coincident strobe: emit old cur and take the first new step now
            r_acc  <= w_cur_sc + w_delta_new_ext;
            r_dout <= r_cur;
         end else begin
            r_acc  <= w_cur_sc;
         end
      end else if (i_step) begin
         r_dout <= w_out;
         if (!i_hold) begin
            r_acc <= r_acc + w_delta_ext;
         end
      end
   end

   assign o_dout = r_dout;

endmodule

`default_nettype wire

// File: rtl/jt5205_interpol_nx.sv
//------------------------------------------------------------------------------
// Module      : jt5205_interpol_nx
// Description : CH-channel 2^LOG2N linear interpolator; owns the shared phase.
//               Optional JT5205_INTERPOL_ROUND_EN enables rounded output.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jt5205_interpol_nx
   import jt5205_pkg::*;
#(
   parameter int DW    = c_def_dw,
   parameter int LOG2N = c_def_log2n,
   parameter int CH    = 1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cen_in,
   input  logic             cen_out,
   input  logic [CH*DW-1:0] din,
   output logic [CH*DW-1:0] dout,
   output logic             dout_cen
);

   localparam int             c_pw   = phase_w(LOG2N);
   localparam logic [c_pw-1:0] c_hold = c_pw'(hold_n(LOG2N));

   logic [c_pw-1:0] r_phase;
   logic            r_dout_cen;
   logic            w_hold;

   assign w_hold = (r_phase == c_hold);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase    <= c_hold;
         r_dout_cen <= 1'b0;
      end else begin
         r_dout_cen <= cen_out;
         if (cen_in) begin
            r_phase <= cen_out ? c_pw'(1) : '0;
         end else if (cen_out && !w_hold) begin
            r_phase <= r_phase + c_pw'(1);
         end
      end
   end

   assign dout_cen = r_dout_cen;

   generate
      for (genvar k = 0; k < CH; k++) begin : g_ch
         jt5205_interpol_ch #(
            .DW    (DW),
            .LOG2N (LOG2N)
         ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_load (cen_in),
            .i_step (cen_out),
            .i_hold (w_hold),
            .i_din  (din[k*DW +: DW]),
            .o_dout (dout[k*DW +: DW])
         );
      end
   endgenerate

endmodule

`default_nettype wire
